data_port_arbiter: RTL and testbench
====================================

Name: data_port_arbiter

Overview:
Shares data-RAM port A between two requesters: the incoming sample stream and the controller's MAC-operand accesses.
- Owns the circular sample buffer inside data RAM and exports its write head (wr_ptr), from which the controller derives data_lptr.
- Controller has priority; sample writes have bounded latency via a wait counter.
- Sits between the controller top, the sample input interface, and the dual-port data RAM.

Parameters:
DATA_ADDR_WIDTH, 6, data RAM address width
DATA_WIDTH, 16, sample/word width
BUF_BASE, 0, first address of circular sample buffer
BUF_LEN, 16, buffer length in words (>=2, BUF_BASE+BUF_LEN <= 2^DATA_ADDR_WIDTH)
MAX_WAIT, 3, max cycles a pending sample may be blocked by controller (>=1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  arbitration enable
smp_valid  in  1  sample offered
smp_data  in  DATA_WIDTH  sample value
smp_ready  out  1  sample accepted when valid&ready
ctrl_req  in  1  controller access request
ctrl_we  in  1  1=write, 0=read
ctrl_addr  in  DATA_ADDR_WIDTH  controller address
ctrl_wdata  in  DATA_WIDTH  controller write data
ctrl_gnt  out  1  controller request granted this cycle (combinational)
ctrl_rvalid  out  1  controller read data valid
ctrl_rdata  out  DATA_WIDTH  read data (ram_rdata passthrough)
ram_en  out  1  port A enable (registered)
ram_we  out  1  port A write (registered)
ram_addr  out  DATA_ADDR_WIDTH  port A address (registered)
ram_wdata  out  DATA_WIDTH  port A write data (registered)
ram_rdata  in  DATA_WIDTH  port A read data, synchronous RAM, 1-cycle latency
wr_ptr  out  DATA_ADDR_WIDTH  next sample write address
new_smp  out  1  one-cycle pulse, sample committed to RAM
overflow  out  1  sticky sample-loss flag

Behaviour:
- Reset (rst=0, async): ram_en/ram_we/ram_addr/ram_wdata=0, ctrl_rvalid=0, new_smp=0, overflow=0, wr_ptr=BUF_BASE, pending=0, wait_cnt=0, state=IDLE.
- Skid register: one entry (pending, pend_data). smp_ready = en & ~pending. On valid&ready, pend_data<=smp_data, pending<=1.
- Arbitration is combinational each cycle with en=1:
  - smp_sel = pending & (~ctrl_req | wait_cnt==MAX_WAIT).
  - ctrl_gnt = ctrl_req & ~smp_sel.
- wait_cnt:
  - +1 each cycle pending=1 and not smp_sel.
  - Cleared on smp_sel.
  - Saturates at MAX_WAIT.
- FSM (registered grant owner):
  - IDLE: nothing granted.
  - CTRL: previous cycle granted controller.
  - SMP: previous cycle granted sample.
  - Next state from smp_sel/ctrl_gnt; IDLE when neither.
- RAM drive, registered, one cycle after grant:
  - smp_sel: ram_en=1, ram_we=1, ram_addr=wr_ptr, ram_wdata=pend_data.
  - ctrl_gnt: ram_en=1, ram_we=ctrl_we, ram_addr=ctrl_addr, ram_wdata=ctrl_wdata.
  - Otherwise ram_en=0, ram_we=0; address/data hold.
- Sample commit, same edge the RAM write is registered:
  - pending<=0; new_smp=1 for one cycle; wr_ptr advances.
  - wr_ptr==BUF_BASE+BUF_LEN-1 wraps to BUF_BASE.
  - A new sample may be accepted the cycle after commit (smp_ready back to 1).
- Controller read latency: ctrl_rvalid=1 exactly two cycles after ctrl_gnt with ctrl_we=0. ctrl_rdata valid only while ctrl_rvalid=1.
- en=0:
  - No grants; smp_ready=0; ctrl_gnt=0.
  - pending, wait_cnt and wr_ptr held.
  - Accesses already registered still complete, including rvalid.
- Simultaneous smp_valid and commit in the same cycle: not possible, since smp_ready=0 while pending.
- Reset mid-access: an in-flight rvalid is lost; the pending sample is discarded.

Optional Feature:
SMP_DROP_EN.
- Defined:
  - smp_ready = en.
  - A sample arriving while pending=1 overwrites pend_data, leaves wait_cnt unchanged, and sets overflow=1 (sticky until reset).
- Undefined: backpressure exactly as above; overflow tied to 0.

Decomposition:
- Shared package: FSM state encoding (IDLE/CTRL/SMP, 2 bits) and grant-source constants.
- Sub-module buf_ptr_wrap holds wr_ptr: load BUF_BASE, increment with wrap at BUF_BASE+BUF_LEN-1.

Test Plan:
1. Reset, en=1, samples 0x0011, 0x0022 with no ctrl_req -> ram_we pulses at addr 0 then 1; wr_ptr=2; two new_smp pulses.
2. 17 samples, BUF_LEN=16 -> 17th written at addr 0; wr_ptr=1 after.
3. ctrl_req held high with reads of addr 0x20 and a pending sample, MAX_WAIT=3 -> sample granted on the 4th cycle after pending; ctrl_gnt=0 that cycle only.
4. Controller read of addr 5 holding 0xBEEF -> ctrl_rvalid=1 with ctrl_rdata=0xBEEF two cycles after ctrl_gnt.
5. en dropped with a pending sample -> no RAM access; pending held; written on the first cycle en returns.
6. SMP_DROP_EN with ctrl_req held, back-to-back samples 0xA, 0xB -> 0xB written, 0xA lost, overflow=1. Without the macro: smp_ready=0 on the 2nd sample, overflow=0.

Source files
------------

// File: rtl/data_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// data_port_arbiter_pkg
// Shared definitions for the data-RAM port A arbiter: the grant-source
// encoding and the registered grant-owner FSM states built on it, plus
// a helper that picks the next owner from this cycle's grant decision.
// -----------------------------------------------------------------------------
package data_port_arbiter_pkg;

  // Grant-source codes; the FSM state is simply "who owned the port last cycle".
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_CTRL = 2'd1;
  localparam logic [1:0] GNT_SMP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = GNT_NONE,
    ST_CTRL = GNT_CTRL,
    ST_SMP  = GNT_SMP
  } arb_state_e;

  // Sample selection always wins over a controller grant (they are exclusive anyway).
  function automatic arb_state_e next_owner(input logic smp_sel, input logic ctrl_gnt);
    arb_state_e st;
    if (smp_sel) begin
      st = ST_SMP;
    end else if (ctrl_gnt) begin
      st = ST_CTRL;
    end else begin
      st = ST_IDLE;
    end
    return st;
  endfunction

endpackage

// File: rtl/data_port_arbiter_buf_ptr_wrap.sv
// -----------------------------------------------------------------------------
// buf_ptr_wrap
// Circular-buffer write head. Resets to BUF_BASE, advances by one on inc and
// wraps from BUF_BASE+BUF_LEN-1 back to BUF_BASE.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   inc  - advance the pointer this cycle
//   ptr  - current write address
// -----------------------------------------------------------------------------
module buf_ptr_wrap
  import data_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned BUF_BASE = 0,
  parameter int unsigned BUF_LEN  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BUF_BASE);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(BUF_BASE + BUF_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  logic [ADDR_W-1:0] ptr_r;

  // Write-head register with wrap at the last buffer word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= BASE_A;
    end else if (inc) begin
      if (ptr_r == LAST_A) begin
        ptr_r <= BASE_A;
      end else begin
        ptr_r <= ptr_r + ONE_A;
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/data_port_arbiter.sv
// -----------------------------------------------------------------------------
// data_port_arbiter
// Shares data-RAM port A between the incoming sample stream and controller
// MAC-operand accesses. The controller has priority, but a buffered sample is
// forced through after MAX_WAIT blocked cycles. Owns the circular sample
// buffer write head (wr_ptr). RAM port signals are registered one cycle after
// the grant; controller read data is valid two cycles after the grant.
//
// Build option: define SMP_DROP_EN to make the sample input always ready; a
// sample arriving while one is still buffered replaces it and sets the sticky
// overflow flag. Without it the input back-pressures and overflow stays 0.
//
// Ports:
//   clk, rst (async active-low), en (arbitration enable)
//   smp_valid/smp_data/smp_ready          - sample stream handshake
//   ctrl_req/ctrl_we/ctrl_addr/ctrl_wdata - controller request
//   ctrl_gnt (combinational), ctrl_rvalid, ctrl_rdata
//   ram_en/ram_we/ram_addr/ram_wdata (registered), ram_rdata
//   wr_ptr (next sample address), new_smp (commit pulse), overflow (sticky)
// -----------------------------------------------------------------------------
module data_port_arbiter
  import data_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned BUF_BASE        = 0,
  parameter int unsigned BUF_LEN         = 16,
  parameter int unsigned MAX_WAIT        = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       smp_valid,
  input  logic [DATA_WIDTH-1:0]      smp_data,
  output logic                       smp_ready,
  input  logic                       ctrl_req,
  input  logic                       ctrl_we,
  input  logic [DATA_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [DATA_WIDTH-1:0]      ctrl_wdata,
  output logic                       ctrl_gnt,
  output logic                       ctrl_rvalid,
  output logic [DATA_WIDTH-1:0]      ctrl_rdata,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [DATA_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_wdata,
  input  logic [DATA_WIDTH-1:0]      ram_rdata,
  output logic [DATA_ADDR_WIDTH-1:0] wr_ptr,
  output logic                       new_smp,
  output logic                       overflow
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  arb_state_e                 state_r;
  arb_state_e                 nxt_state_s;
  logic                       pending_r;
  logic [DATA_WIDTH-1:0]      pend_data_r;
  logic [WAIT_W-1:0]          wait_cnt_r;
  logic                       smp_sel_s;
  logic                       ctrl_gnt_s;
  logic                       smp_ready_s;
  logic                       smp_acc_s;
  logic                       rd_issued_s;
  logic                       ctrl_rvalid_r;
  logic                       ram_en_r;
  logic                       ram_we_r;
  logic [DATA_ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0]      ram_wdata_r;
  logic                       new_smp_r;
  logic [DATA_ADDR_WIDTH-1:0] wr_ptr_s;

  // Input-ready and per-cycle grant decision; nothing is granted while en=0.
  always_comb begin
    smp_ready_s = 1'b0;
    smp_sel_s   = 1'b0;
    ctrl_gnt_s  = 1'b0;
    if (en) begin
`ifdef SMP_DROP_EN
      smp_ready_s = 1'b1;
`else
      smp_ready_s = ~pending_r;
`endif
      smp_sel_s  = pending_r & (~ctrl_req | (wait_cnt_r == WAIT_MAX));
      ctrl_gnt_s = ctrl_req & ~smp_sel_s;
    end else begin
      smp_ready_s = 1'b0;
      smp_sel_s   = 1'b0;
      ctrl_gnt_s  = 1'b0;
    end
    smp_acc_s   = smp_valid & smp_ready_s;
    nxt_state_s = next_owner(smp_sel_s, ctrl_gnt_s);
  end

  // A read was presented to the RAM last cycle exactly when the controller owned it with we=0.
  assign rd_issued_s = (state_r == ST_CTRL) & ~ram_we_r;

  // Skid register and starvation counter for the buffered sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_r   <= 1'b0;
      pend_data_r <= {DATA_WIDTH{1'b0}};
      wait_cnt_r  <= {WAIT_W{1'b0}};
    end else begin
      // An accept coinciding with a commit (drop build only) keeps the entry full.
      if (smp_acc_s) begin
        pending_r   <= 1'b1;
        pend_data_r <= smp_data;
      end else if (smp_sel_s) begin
        pending_r   <= 1'b0;
        pend_data_r <= pend_data_r;
      end else begin
        pending_r   <= pending_r;
        pend_data_r <= pend_data_r;
      end
      if (smp_sel_s) begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end else if (en && pending_r && (wait_cnt_r != WAIT_MAX)) begin
        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Grant-owner FSM with the registered RAM port drive and commit pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      ram_en_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {DATA_ADDR_WIDTH{1'b0}};
      ram_wdata_r <= {DATA_WIDTH{1'b0}};
      new_smp_r   <= 1'b0;
    end else begin
      state_r   <= nxt_state_s;
      new_smp_r <= smp_sel_s;
      case (nxt_state_s)
        ST_SMP: begin
          ram_en_r    <= 1'b1;
          ram_we_r    <= 1'b1;
          ram_addr_r  <= wr_ptr_s;
          ram_wdata_r <= pend_data_r;
        end
        ST_CTRL: begin
          ram_en_r    <= 1'b1;
          ram_we_r    <= ctrl_we;
          ram_addr_r  <= ctrl_addr;
          ram_wdata_r <= ctrl_wdata;
        end
        default: begin
          // Address and data hold so the idle port does not toggle.
          ram_en_r    <= 1'b0;
          ram_we_r    <= 1'b0;
          ram_addr_r  <= ram_addr_r;
          ram_wdata_r <= ram_wdata_r;
        end
      endcase
    end
  end

  // Read-data valid: RAM output arrives the cycle after the read was presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_rvalid_r <= 1'b0;
    end else begin
      ctrl_rvalid_r <= rd_issued_s;
    end
  end

`ifdef SMP_DROP_EN
  logic overflow_r;

  // Sticky loss flag: a buffered sample was replaced before it reached the RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r | (smp_acc_s & pending_r & ~smp_sel_s);
    end
  end

  assign overflow = overflow_r;
`else
  assign overflow = 1'b0;
`endif

  buf_ptr_wrap #(
    .ADDR_W   (DATA_ADDR_WIDTH),
    .BUF_BASE (BUF_BASE),
    .BUF_LEN  (BUF_LEN)
  ) u_buf_ptr_wrap (
    .clk (clk),
    .rst (rst),
    .inc (smp_sel_s),
    .ptr (wr_ptr_s)
  );

  assign smp_ready   = smp_ready_s;
  assign ctrl_gnt    = ctrl_gnt_s;
  assign ctrl_rvalid = ctrl_rvalid_r;
  assign ctrl_rdata  = ram_rdata;
  assign ram_en      = ram_en_r;
  assign ram_we      = ram_we_r;
  assign ram_addr    = ram_addr_r;
  assign ram_wdata   = ram_wdata_r;
  assign wr_ptr      = wr_ptr_s;
  assign new_smp     = new_smp_r;

endmodule

// File: tb/tb_data_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_port_arbiter
// Directed bench for data_port_arbiter with default parameters
// (6-bit address, 16-bit data, buffer 0..15, MAX_WAIT=3) and a small
// synchronous RAM model on port A. Honours SMP_DROP_EN for the drop scenario.
// -----------------------------------------------------------------------------
module tb_data_port_arbiter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic        smp_ready;
  logic        ctrl_req;
  logic        ctrl_we;
  logic [5:0]  ctrl_addr;
  logic [15:0] ctrl_wdata;
  logic        ctrl_gnt;
  logic        ctrl_rvalid;
  logic [15:0] ctrl_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [5:0]  wr_ptr;
  logic        new_smp;
  logic        overflow;

  logic [15:0] mem [0:63];
  logic [15:0] exp_data;
  logic        exp_bit;

  int vectors;
  int miscompares;

  data_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .smp_ready   (smp_ready),
    .ctrl_req    (ctrl_req),
    .ctrl_we     (ctrl_we),
    .ctrl_addr   (ctrl_addr),
    .ctrl_wdata  (ctrl_wdata),
    .ctrl_gnt    (ctrl_gnt),
    .ctrl_rvalid (ctrl_rvalid),
    .ctrl_rdata  (ctrl_rdata),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .wr_ptr      (wr_ptr),
    .new_smp     (new_smp),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous single-port RAM model, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d);
    smp_valid = 1'b1;
    smp_data  = d;
    tick();
    smp_valid = 1'b0;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    en          = 1'b0;
    smp_valid   = 1'b0;
    smp_data    = 16'h0000;
    ctrl_req    = 1'b0;
    ctrl_we     = 1'b0;
    ctrl_addr   = 6'd0;
    ctrl_wdata  = 16'h0000;
    tick();
    tick();

    // Reset state
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", {26'd0, ram_addr}, 32'd0);
    chk("rst_wr_ptr", {26'd0, wr_ptr}, 32'd0);
    chk("rst_new_smp", {31'd0, new_smp}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_rvalid", {31'd0, ctrl_rvalid}, 32'd0);
    rst = 1'b1;
    en  = 1'b1;
    tick();

    // Controller write 0xBEEF to addr 5, then read it back
    ctrl_req = 1'b1; ctrl_we = 1'b1; ctrl_addr = 6'd5; ctrl_wdata = 16'hBEEF;
    #1;
    chk("t4_gnt_wr", {31'd0, ctrl_gnt}, 32'd1);
    tick();
    chk("t4_ram_en_wr", {31'd0, ram_en}, 32'd1);
    chk("t4_ram_we_wr", {31'd0, ram_we}, 32'd1);
    chk("t4_ram_addr_wr", {26'd0, ram_addr}, 32'd5);
    chk("t4_ram_wdata", {16'd0, ram_wdata}, 32'h0000BEEF);
    ctrl_we = 1'b0;
    #1;
    chk("t4_gnt_rd", {31'd0, ctrl_gnt}, 32'd1);
    tick();
    ctrl_req = 1'b0;
    chk("t4_ram_en_rd", {31'd0, ram_en}, 32'd1);
    chk("t4_ram_we_rd", {31'd0, ram_we}, 32'd0);
    chk("t4_rvalid_early", {31'd0, ctrl_rvalid}, 32'd0);
    tick();
    chk("t4_rvalid", {31'd0, ctrl_rvalid}, 32'd1);
    chk("t4_rdata", {16'd0, ctrl_rdata}, 32'h0000BEEF);
    chk("t4_ram_idle", {31'd0, ram_en}, 32'd0);
    tick();
    chk("t4_rvalid_off", {31'd0, ctrl_rvalid}, 32'd0);

    // Two samples with no controller traffic
    smp_valid = 1'b1; smp_data = 16'h0011;
    #1;
    chk("t1_ready", {31'd0, smp_ready}, 32'd1);
    tick();
    smp_valid = 1'b0;
    #1;
    chk("t1_ready_pend", {31'd0, smp_ready}, 32'd0);
    chk("t1_new_smp_early", {31'd0, new_smp}, 32'd0);
    tick();
    chk("t1_ram_we0", {31'd0, ram_we}, 32'd1);
    chk("t1_ram_addr0", {26'd0, ram_addr}, 32'd0);
    chk("t1_ram_wdata0", {16'd0, ram_wdata}, 32'h00000011);
    chk("t1_new_smp0", {31'd0, new_smp}, 32'd1);
    chk("t1_wr_ptr1", {26'd0, wr_ptr}, 32'd1);
    send(16'h0022);
    chk("t1_ram_addr1", {26'd0, ram_addr}, 32'd1);
    chk("t1_ram_wdata1", {16'd0, ram_wdata}, 32'h00000022);
    chk("t1_new_smp1", {31'd0, new_smp}, 32'd1);
    chk("t1_wr_ptr2", {26'd0, wr_ptr}, 32'd2);
    tick();
    chk("t1_new_smp_pulse", {31'd0, new_smp}, 32'd0);

    // Reset, then 17 samples to exercise the wrap
    rst = 1'b0;
    tick();
    chk("t2_rst_wr_ptr", {26'd0, wr_ptr}, 32'd0);
    chk("t2_rst_ram_en", {31'd0, ram_en}, 32'd0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      send(16'h0100 + 16'(i));
      if (i == 15) begin
        chk("t2_addr15", {26'd0, ram_addr}, 32'd15);
        chk("t2_wrap_ptr", {26'd0, wr_ptr}, 32'd0);
      end
    end
    chk("t2_addr_wrap", {26'd0, ram_addr}, 32'd0);
    chk("t2_wdata17", {16'd0, ram_wdata}, 32'h00000110);
    chk("t2_wr_ptr1", {26'd0, wr_ptr}, 32'd1);

    // Controller hogs the port; sample forced through after MAX_WAIT
    ctrl_req = 1'b1; ctrl_we = 1'b0; ctrl_addr = 6'h20;
    smp_valid = 1'b1; smp_data = 16'h0033;
    #1;
    chk("t3_gnt_pre", {31'd0, ctrl_gnt}, 32'd1);
    tick();
    smp_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("t3_gnt", {31'd0, ctrl_gnt}, (k == 4) ? 32'd0 : 32'd1);
      tick();
      if (k == 3) begin
        chk("t3_ctrl_addr", {26'd0, ram_addr}, 32'h20);
        chk("t3_ctrl_we", {31'd0, ram_we}, 32'd0);
      end
    end
    chk("t3_smp_we", {31'd0, ram_we}, 32'd1);
    chk("t3_smp_addr", {26'd0, ram_addr}, 32'd1);
    chk("t3_smp_wdata", {16'd0, ram_wdata}, 32'h00000033);
    chk("t3_new_smp", {31'd0, new_smp}, 32'd1);
    #1;
    chk("t3_gnt_back", {31'd0, ctrl_gnt}, 32'd1);
    ctrl_req = 1'b0;
    tick();
    tick();

    // en dropped with a sample buffered
    smp_valid = 1'b1; smp_data = 16'h0055;
    tick();
    smp_valid = 1'b0;
    en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t5_ready_off", {31'd0, smp_ready}, 32'd0);
      tick();
      chk("t5_no_access", {31'd0, ram_en}, 32'd0);
    end
    chk("t5_ptr_held", {26'd0, wr_ptr}, 32'd2);
    en = 1'b1;
    tick();
    chk("t5_we", {31'd0, ram_we}, 32'd1);
    chk("t5_addr", {26'd0, ram_addr}, 32'd2);
    chk("t5_wdata", {16'd0, ram_wdata}, 32'h00000055);
    chk("t5_wr_ptr", {26'd0, wr_ptr}, 32'd3);
    tick();

    // Back-to-back samples while the controller holds the port
`ifdef SMP_DROP_EN
    exp_data = 16'h000B;
    exp_bit  = 1'b1;
`else
    exp_data = 16'h000A;
    exp_bit  = 1'b0;
`endif
    ctrl_req = 1'b1; ctrl_we = 1'b0; ctrl_addr = 6'h20;
    smp_valid = 1'b1; smp_data = 16'h000A;
    tick();
    smp_data = 16'h000B;
    #1;
    chk("t6_ready_2nd", {31'd0, smp_ready}, {31'd0, exp_bit});
    tick();
    smp_valid = 1'b0;
    chk("t6_overflow", {31'd0, overflow}, {31'd0, exp_bit});
    tick();
    tick();
    tick();
    chk("t6_we", {31'd0, ram_we}, 32'd1);
    chk("t6_addr", {26'd0, ram_addr}, 32'd3);
    chk("t6_wdata", {16'd0, ram_wdata}, {16'd0, exp_data});
    chk("t6_wr_ptr", {26'd0, wr_ptr}, 32'd4);
    chk("t6_overflow_sticky", {31'd0, overflow}, {31'd0, exp_bit});
    ctrl_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
